// File: rtl/ws2812_pkg.sv
// Shared types and sizes for the ws2812 write path: state encoding,
// requester count and colour widths, plus the round-robin pick helper.
package ws2812_pkg;

  localparam int NUM_REQ = 2;
  localparam int CH_W    = 8;
  localparam int RGB_W   = 24;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Index of the requester to grant; with both valid, the one not granted last.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid, input logic last_grant);
    if (valid[0] && valid[1]) begin
      return ~last_grant;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/ws2812_scale8.sv
// One colour channel scaled by a brightness factor: (c * (b+1)) >> 8.
// b=255 passes the channel through unchanged; b=0 maps every value to 0.
module ws2812_scale8
  import ws2812_pkg::*;
(
  input  logic [CH_W-1:0] chan,
  input  logic [CH_W-1:0] scale,
  output logic [CH_W-1:0] scaled
);

  logic [16:0] product;

  assign product = {9'd0, chan} * ({9'd0, scale} + 17'd1);
  assign scaled  = CH_W'(product >> CH_W);

endmodule

// File: rtl/ws2812_write_arbiter.sv
// Two-requester round-robin burst arbiter feeding a ws2812 driver write port,
// with per-burst brightness scaling, out-of-range drop and idle timeout.
module ws2812_write_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [7:0]         req0_led,
  input  logic [7:0]         req1_led,
  input  logic [RGB_W-1:0]   req0_rgb,
  input  logic [RGB_W-1:0]   req1_rgb,
  input  logic [CH_W-1:0]    brightness,
  output logic               led_write,
  output logic [7:0]         led_num,
  output logic [RGB_W-1:0]   led_rgb,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_pulse,
  output logic               drop_pulse
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic               last_grant_reg;
  logic [CH_W-1:0]    bright_reg;
  logic [CNT_W-1:0]   idle_cnt_reg;
  logic               led_write_reg;
  logic [7:0]         led_num_reg;
  logic [RGB_W-1:0]   led_rgb_reg;
  logic               timeout_pulse_reg;
  logic               drop_pulse_reg;

  logic             sel;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_led;
  logic [RGB_W-1:0] sel_rgb;
  logic [RGB_W-1:0] scaled_rgb;
  logic             in_range;

  // Only the granted requester's beat reaches the datapath.
  assign sel       = grant_reg[1];
  assign sel_valid = req_valid[sel];
  assign sel_last  = req_last[sel];
  assign sel_led   = sel ? req1_led : req0_led;
  assign sel_rgb   = sel ? req1_rgb : req0_rgb;
  assign in_range  = {24'd0, sel_led} < 32'(NUM_LEDS);

  for (genvar gi = 0; gi < RGB_W / CH_W; gi++) begin : g_scale
    ws2812_scale8 u_scale (
      .chan   (sel_rgb[gi*CH_W +: CH_W]),
      .scale  (bright_reg),
      .scaled (scaled_rgb[gi*CH_W +: CH_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      grant_reg         <= '0;
      last_grant_reg    <= 1'b1;
      bright_reg        <= '0;
      idle_cnt_reg      <= '0;
      led_write_reg     <= 1'b0;
      led_num_reg       <= '0;
      led_rgb_reg       <= '0;
      timeout_pulse_reg <= 1'b0;
      drop_pulse_reg    <= 1'b0;
    end else begin
      led_write_reg     <= 1'b0;
      timeout_pulse_reg <= 1'b0;
      drop_pulse_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_reg    <= rr_pick(req_valid, last_grant_reg) ? 2'b10 : 2'b01;
            state_reg    <= ST_BURST;
            bright_reg   <= brightness;
            idle_cnt_reg <= '0;
          end
        end
        ST_BURST: begin
          if (sel_valid) begin
            idle_cnt_reg <= '0;
            if (in_range) begin
              led_write_reg <= 1'b1;
              led_num_reg   <= sel_led;
              led_rgb_reg   <= scaled_rgb;
            end else begin
              drop_pulse_reg <= 1'b1;
            end
            if (sel_last) begin
              state_reg      <= ST_IDLE;
              grant_reg      <= '0;
              last_grant_reg <= sel;
            end
          end else if (idle_cnt_reg >= CNT_LAST) begin
            // Requester stalled too long: revoke so the other side can proceed.
            state_reg         <= ST_IDLE;
            grant_reg         <= '0;
            last_grant_reg    <= sel;
            timeout_pulse_reg <= 1'b1;
            idle_cnt_reg      <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state_reg == ST_BURST);
  assign req_ready     = busy ? grant_reg : '0;
  assign grant         = grant_reg;
  assign led_write     = led_write_reg;
  assign led_num       = led_num_reg;
  assign led_rgb       = led_rgb_reg;
  assign timeout_pulse = timeout_pulse_reg;
  assign drop_pulse    = drop_pulse_reg;

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Scoreboard bench for ws2812_write_arbiter: stimulus pushes predicted events,
// a negedge monitor pops and compares whenever the DUT emits write/drop/timeout.
module tb_ws2812_write_arbiter;

  localparam int NL = 8;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req0_led = '0;
  logic [7:0]  req1_led = '0;
  logic [23:0] req0_rgb = '0;
  logic [23:0] req1_rgb = '0;
  logic [7:0]  brightness = '0;
  logic        led_write;
  logic [7:0]  led_num;
  logic [23:0] led_rgb;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_pulse;
  logic        drop_pulse;

  always #5 clk = ~clk;

  ws2812_write_arbiter #(.NUM_LEDS(NL), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .req0_led      (req0_led),
    .req1_led      (req1_led),
    .req0_rgb      (req0_rgb),
    .req1_rgb      (req1_rgb),
    .brightness    (brightness),
    .led_write     (led_write),
    .led_num       (led_num),
    .led_rgb       (led_rgb),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .drop_pulse    (drop_pulse)
  );

  typedef struct packed {
    logic [7:0]  led;
    logic [23:0] rgb;
    logic        last;
  } beat_t;

  // kind: 0 = led write, 1 = drop, 2 = timeout
  typedef struct {
    int          kind;
    logic [7:0]  num;
    logic [23:0] rgb;
  } ev_t;

  ev_t         sb[$];
  int          owner_q[$];
  beat_t       bq0[$];
  beat_t       bq1[$];
  int          total = 0;
  int          bad = 0;
  int          writes = 0;
  int          last_g = 1;
  logic [7:0]  hold_num = '0;
  logic [23:0] hold_rgb = '0;
  ev_t         mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] scale_rgb(input logic [23:0] c, input logic [7:0] b);
    logic [23:0] res;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      int ch;
      ch = int'((c >> (8 * i)) & 24'hFF);
      res = res | (24'((ch * (int'(b) + 1)) / 256) << (8 * i));
    end
    return res;
  endfunction

  function automatic beat_t mk_beat(input logic [7:0] led, input logic [23:0] rgb, input logic last);
    beat_t b;
    b.led  = led;
    b.rgb  = rgb;
    b.last = last;
    return b;
  endfunction

  task automatic push_ev(input int kind, input logic [7:0] num, input logic [23:0] rgb);
    ev_t e;
    e.kind = kind;
    e.num  = num;
    e.rgb  = rgb;
    sb.push_back(e);
  endtask

  task automatic predict(input int r, input logic [7:0] br);
    int n;
    beat_t b;
    n = (r == 0) ? bq0.size() : bq1.size();
    for (int k = 0; k < n; k++) begin
      b = (r == 0) ? bq0[k] : bq1[k];
      if (int'(b.led) < NL) push_ev(0, b.led, scale_rgb(b.rgb, br));
      else push_ev(1, '0, '0);
    end
  endtask

  task automatic set_beat(input int r, input beat_t b);
    if (r == 0) begin
      req0_led = b.led; req0_rgb = b.rgb; req_last[0] = b.last;
    end else begin
      req1_led = b.led; req1_rgb = b.rgb; req_last[1] = b.last;
    end
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_ready(input int r, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (req_ready[r]) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL ready_wait: requester %0d got no ready within 200 cycles, required ready", r);
  endtask

  task automatic check_owner(input int r);
    if (owner_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL grant_owner: got requester %0d, required no grant", r);
    end else begin
      chk("grant_owner", r, owner_q.pop_front());
    end
    chk("grant_onehot", grant, 32'(1 << r));
  endtask

  // Runs requester r's queued burst; returns on the negedge after the final accept.
  task automatic drive(input int r, input int stall_max);
    int n;
    beat_t b;
    bit ok;
    n = (r == 0) ? bq0.size() : bq1.size();
    for (int k = 0; k < n; k++) begin
      b = (r == 0) ? bq0[k] : bq1[k];
      if (k > 0) begin
        req_valid[r] = 1'b0;
        repeat ($urandom_range(0, stall_max)) @(negedge clk);
      end
      set_beat(r, b);
      wait_ready(r, ok);
      if (!ok) begin
        req_valid[r] = 1'b0;
        return;
      end
      if (k == 0) check_owner(r);
      @(posedge clk);
      @(negedge clk);
      if (b.last) chk("idle_after_last", busy, 0);
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic fill(input int r, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b = mk_beat(8'($urandom_range(0, 10)), 24'($urandom), k == n - 1);
      if (r == 0) bq0.push_back(b);
      else bq1.push_back(b);
    end
  endtask

  task automatic rand_round(input int mask);
    logic [7:0] br;
    int first;
    br = 8'($urandom);
    bq0.delete();
    bq1.delete();
    if ((mask & 1) != 0) fill(0, $urandom_range(1, 3));
    if ((mask & 2) != 0) fill(1, $urandom_range(1, 3));
    brightness = br;
    if (mask == 3) begin
      first = (last_g == 0) ? 1 : 0;
      predict(first, br);
      predict(1 - first, br);
      owner_q.push_back(first);
      owner_q.push_back(1 - first);
      last_g = 1 - first;
    end else begin
      first = (mask == 1) ? 0 : 1;
      predict(first, br);
      owner_q.push_back(first);
      last_g = first;
    end
    fork
      begin if ((mask & 1) != 0) drive(0, 2); end
      begin if ((mask & 2) != 0) drive(1, 2); end
    join
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ready_rule", req_ready, busy ? grant : 2'b00);
        if (led_write || drop_pulse || timeout_pulse) begin
          int ka;
          ka = led_write ? 0 : (drop_pulse ? 1 : 2);
          chk("single_event", int'(led_write) + int'(drop_pulse) + int'(timeout_pulse), 1);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d, required none", ka);
          end else begin
            mon_e = sb.pop_front();
            chk("event_kind", ka, mon_e.kind);
            if (mon_e.kind == 0) begin
              chk("led_num", led_num, mon_e.num);
              chk("led_rgb", led_rgb, mon_e.rgb);
              hold_num = mon_e.num;
              hold_rgb = mon_e.rgb;
              writes++;
            end
          end
        end
        if (!led_write) begin
          chk("hold_num", led_num, hold_num);
          chk("hold_rgb", led_rgb, hold_rgb);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    int t;
    bit ok;
    logic [23:0] c;

    // Reset with both requesters valid: nothing may leak through.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_write", led_write, 0);
    chk("rst_num", led_num, 0);
    chk("rst_rgb", led_rgb, 0);
    chk("rst_pulses", {timeout_pulse, drop_pulse}, 0);
    #1;
    req_valid = 2'b00;
    reset = 1'b0;

    // Tie after reset: requester 0 first, then 1, four writes in total.
    brightness = 8'd255;
    bq0.delete(); bq1.delete();
    bq0.push_back(mk_beat(8'd3, 24'h80FF01, 1'b0));
    bq0.push_back(mk_beat(8'd5, 24'h123456, 1'b1));
    bq1.push_back(mk_beat(8'd0, 24'hABCDEF, 1'b0));
    bq1.push_back(mk_beat(8'd7, 24'h000001, 1'b1));
    push_ev(0, 8'd3, 24'h80FF01);
    predict(0, 8'd255);
    void'(sb.pop_back());
    void'(sb.pop_back());
    push_ev(0, 8'd5, 24'h123456);
    predict(1, 8'd255);
    owner_q.push_back(0);
    owner_q.push_back(1);
    last_g = 1;
    wb = writes;
    fork
      drive(0, 0);
      drive(1, 0);
    join
    @(negedge clk);
    chk("four_writes", writes - wb, 4);

    // Brightness latched at burst start despite a mid-burst change.
    brightness = 8'd127;
    bq0.delete(); bq1.delete();
    for (int k = 0; k < 3; k++) begin
      bq1.push_back(mk_beat(8'(k), 24'hFF8002, k == 2));
      push_ev(0, 8'(k), 24'h7F4001);
    end
    owner_q.push_back(1);
    last_g = 1;
    fork
      drive(1, 0);
      begin repeat (2) @(negedge clk); brightness = 8'd0; end
    join

    // Out-of-range LED index is consumed and dropped.
    bq0.delete(); bq1.delete();
    bq0.push_back(mk_beat(8'd8, 24'hFFFFFF, 1'b1));
    push_ev(1, '0, '0);
    owner_q.push_back(0);
    last_g = 0;
    drive(0, 0);

    // Stall mid-burst: timeout after TO idle cycles, then the other side gets in.
    brightness = 8'd200;
    bq0.delete(); bq1.delete();
    c = 24'($urandom);
    bq0.push_back(mk_beat(8'd2, c, 1'b0));
    push_ev(0, 8'd2, scale_rgb(c, 8'd200));
    push_ev(2, '0, '0);
    fill(1, 2);
    predict(1, 8'd200);
    owner_q.push_back(0);
    owner_q.push_back(1);
    last_g = 1;
    fork
      begin
        drive(0, 0);
        t = 0;
        while (t < 20) begin
          @(negedge clk);
          t++;
          if (timeout_pulse) break;
        end
        chk("timeout_delay", t, TO);
      end
      begin
        @(negedge clk);
        drive(1, 0);
      end
    join

    for (int rd = 0; rd < 40; rd++) rand_round($urandom_range(1, 3));

    // Reset mid-burst with a valid beat pending.
    brightness = 8'd90;
    bq0.delete(); bq1.delete();
    bq0.push_back(mk_beat(8'd1, 24'h00FF00, 1'b0));
    bq0.push_back(mk_beat(8'd2, 24'hFF0000, 1'b0));
    push_ev(0, 8'd1, scale_rgb(24'h00FF00, 8'd90));
    owner_q.push_back(0);
    set_beat(0, bq0[0]);
    wait_ready(0, ok);
    if (ok) begin
      check_owner(0);
      @(posedge clk);
      @(negedge clk);
      set_beat(0, bq0[1]);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_write", led_write, 0);
      chk("mid_rst_ready", req_ready, 0);
    end
    #1;
    hold_num = '0;
    hold_rgb = '0;
    req_valid = 2'b00;
    reset = 1'b0;
    last_g = 1;
    rand_round(3);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("owners_drained", owner_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_write_arbiter.md
WS2812_WRITE_ARBITER -- requirements
Module: ws2812_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning LED count of the downstream ws2812 driver.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning idle cycles allowed mid-burst before the grant is revoked.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid, req_last, req_ready  input/input/output  2 each  per-requester beat handshake, bit i = requester i.
REQ-006 SHALL have ports req0_led, req1_led  input  8  target LED index per requester.
REQ-007 SHALL have ports req0_rgb, req1_rgb  input  24  GRB colour per requester.
REQ-008 SHALL have port brightness  input  8  global scale factor.
REQ-009 SHALL have ports led_write, led_num, led_rgb  output  1/8/24  write port to the ws2812 driver.
REQ-010 SHALL have ports grant, busy, timeout_pulse, drop_pulse  output  2/1/1/1  status.

Function
REQ-011 SHALL implement states IDLE and BURST; busy = (state == BURST).
REQ-012 In IDLE with any req_valid set, SHALL select one requester round-robin (the one not granted last; if only one is valid, that one), set grant one-hot and enter BURST next cycle.
REQ-013 With both valid in IDLE, SHALL select the requester other than last_grant.
REQ-014 req_ready[i] SHALL equal (state == BURST) && grant[i], combinationally; it SHALL never be high in IDLE.
REQ-015 A beat SHALL be accepted when req_valid[i] && req_ready[i]; the requester holds led/rgb/last stable while valid and not ready.
REQ-016 Accepted beat with req_last=1 SHALL return to IDLE next cycle, clear grant and record last_grant; at least one IDLE cycle separates bursts.
REQ-017 brightness SHALL be latched at the IDLE->BURST transition and held for the whole burst.
REQ-018 Each 8-bit channel SHALL be scaled as (c * (b+1)) >> 8 using 17-bit intermediate; b=255 is identity, b=0 maps 255->0 and 1->0.
REQ-019 An accepted in-range beat (led < NUM_LEDS) SHALL produce led_write=1 for exactly one cycle, on the cycle after acceptance, with registered led_num and scaled led_rgb.
REQ-020 An accepted beat with led >= NUM_LEDS SHALL be consumed (ready honoured, last honoured), SHALL NOT assert led_write, and SHALL pulse drop_pulse one cycle, aligned with where led_write would have been.
REQ-021 In BURST, a counter SHALL count consecutive cycles with granted req_valid low; reaching TIMEOUT SHALL return to IDLE, clear grant, set last_grant, and pulse timeout_pulse one cycle; any accepted beat clears the counter.
REQ-022 led_num and led_rgb SHALL hold their last values when led_write is low.
REQ-023 Ungranted requester's inputs SHALL have no effect on any output.

Reset
REQ-024 reset SHALL take priority over all activity, including mid-burst, with no led_write in the following cycle.
REQ-025 After reset: state IDLE, grant 0, led_write 0, led_num 0, led_rgb 0, timeout/drop pulses 0, timeout counter 0, latched brightness 0, last_grant = 1 so requester 0 wins the first tie.

Structure
REQ-026 State encodings, requester count (2), channel width (8) and RGB width (24) SHALL live in shared package ws2812_pkg.
REQ-027 Channel scaling SHALL be one sub-module, ws2812_scale8, instantiated three times, purely combinational.
REQ-028 Output registers SHALL be the only pipeline stage; no FIFO.

Verification
REQ-029 Both valid after reset, each a 2-beat burst -> requester 0 granted first, then requester 1; one IDLE cycle between; 4 led_write pulses.
REQ-030 brightness=255, beat led=3 rgb=0x80FF01 -> next cycle led_write=1, led_num=3, led_rgb=0x80FF01.
REQ-031 brightness=127 latched, brightness changed to 0 mid-burst, rgb=0xFF8002 -> led_rgb=0x7F4001 for every beat of that burst.
REQ-032 NUM_LEDS=8, beat led=8 with last=1 -> no led_write, drop_pulse=1 one cycle, return to IDLE.
REQ-033 TIMEOUT=4, granted requester drops valid after first beat -> timeout_pulse after 4 idle cycles, grant cleared, other requester granted next.
REQ-034 reset asserted during BURST with valid beat -> next cycle state IDLE, grant=0, led_write=0, req_ready=0.
